// File: rtl/slave_bus_arbiter_if.sv
// slave_bus_arbiter_if: shared-slave-bus bundle between N frame FIFOs,
// the arbiter and the downstream word sink.
// Signals:
//   sl_arb_request  per-requester frame-pending flags (requesters -> arbiter)
//   sl_arb_grant    one-hot grant (arbiter -> requesters)
//   sl_addr         read address into the granted FIFO
//   sl_data         read data from the granted FIFO (combinational)
//   sl_tail         granted FIFO's frame end address (one past last word)
//   sl_latch_tail   one-cycle pulse releasing the served frame
//   out_data/out_valid/out_ready  downstream word handshake
//   out_src         index of the granted requester
//   abort           one-cycle pulse when a transfer is abandoned
//   frames_served   saturating count of completed frames
// Modports: master = arbiter side, slave = environment side.
interface slave_bus_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
);
    logic [NUM_REQ-1:0] sl_arb_request;
    logic [NUM_REQ-1:0] sl_arb_grant;
    logic [8:0]         sl_addr;
    logic [8:0]         sl_data;
    logic [8:0]         sl_tail;
    logic               sl_latch_tail;
    logic [8:0]         out_data;
    logic               out_valid;
    logic               out_ready;
    logic [IDX_W-1:0]   out_src;
    logic               abort;
    logic [15:0]        frames_served;

    modport master (
        input  sl_arb_request,
        input  sl_data,
        input  sl_tail,
        input  out_ready,
        output sl_arb_grant,
        output sl_addr,
        output sl_latch_tail,
        output out_data,
        output out_valid,
        output out_src,
        output abort,
        output frames_served
    );

    modport slave (
        output sl_arb_request,
        output sl_data,
        output sl_tail,
        output out_ready,
        input  sl_arb_grant,
        input  sl_addr,
        input  sl_latch_tail,
        input  out_data,
        input  out_valid,
        input  out_src,
        input  abort,
        input  frames_served
    );
endinterface

// File: rtl/slave_bus_arbiter.sv
// slave_bus_arbiter: round-robin arbiter that drains one frame at a time
// from NUM_REQ ring-buffer FIFOs (512 words, 9-bit) onto a downstream port.
// Ports:
//   clk   clock
//   rst   asynchronous active-high reset
//   bus   slave_bus_arbiter_if.master (request/grant, FIFO read port,
//         downstream valid/ready, source index, abort, frame counter)
module slave_bus_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    slave_bus_arbiter_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        XFER,
        RELEASE
    } state_t;

    localparam logic [IDX_W:0] NREQ = (IDX_W+1)'(NUM_REQ);

    state_t           state;
    state_t           state_d;

    logic [8:0]       hd [NUM_REQ];
    logic [IDX_W-1:0] rr;
    logic [IDX_W-1:0] sel;
    logic [8:0]       tail_q;
    logic [8:0]       ptr;
    logic [15:0]      served;
    logic             abort_q;

    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             found;
    logic [IDX_W-1:0] sel_inc;
    logic [8:0]       hd_sel;
    logic [8:0]       ptr_inc;
    logic             req_sel;
    logic             any_req;

    logic             ld_sel;
    logic             ld_frame;
    logic             adv;
    logic             release_en;
    logic             abort_en;

    // (a + b) mod NUM_REQ; both operands are already below NUM_REQ,
    // so one conditional subtract is enough.
    function automatic logic [IDX_W-1:0] wrap_add(
        input logic [IDX_W-1:0] a,
        input logic [IDX_W:0]   b
    );
        logic [IDX_W:0] s;
        s = {1'b0, a} + b;
        if (s >= NREQ)
            s = s - NREQ;
        return s[IDX_W-1:0];
    endfunction

    assign hd_sel  = hd[sel];
    assign ptr_inc = ptr + 9'd1;
    assign req_sel = bus.sl_arb_request[sel];
    assign any_req = |bus.sl_arb_request;
    assign sel_inc = wrap_add(sel, (IDX_W+1)'(1));

    // First pending request at or after rr, scanning upward with wrap.
    always_comb begin
        pick  = rr;
        cand  = rr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap_add(rr, (IDX_W+1)'(k));
            if (!found && bus.sl_arb_request[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d    = state;
        ld_sel     = 1'b0;
        ld_frame   = 1'b0;
        adv        = 1'b0;
        release_en = 1'b0;
        abort_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    ld_sel  = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req_sel) begin
                    abort_en = 1'b1;
                    state_d  = IDLE;
                end else begin
                    ld_frame = 1'b1;
                    // tail == head means the requester posted an empty frame
                    if (bus.sl_tail == hd_sel)
                        state_d = RELEASE;
                    else
                        state_d = XFER;
                end
            end
            XFER: begin
                // a dropped request wins over a same-cycle accept
                if (!req_sel) begin
                    abort_en = 1'b1;
                    state_d  = IDLE;
                end else if (bus.out_ready) begin
                    adv = 1'b1;
                    if (ptr_inc == tail_q)
                        state_d = RELEASE;
                end
            end
            RELEASE: begin
                release_en = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr      <= '0;
            sel     <= '0;
            tail_q  <= '0;
            ptr     <= '0;
            served  <= '0;
            abort_q <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++)
                hd[i] <= '0;
        end else begin
            abort_q <= abort_en;
            if (ld_sel)
                sel <= pick;
            if (ld_frame) begin
                tail_q <= bus.sl_tail;
                ptr    <= hd_sel;
            end
            if (adv)
                ptr <= ptr_inc;
            if (release_en) begin
                hd[sel] <= tail_q;
                if (served != 16'hFFFF)
                    served <= served + 16'd1;
            end
            if (release_en || abort_en)
                rr <= sel_inc;
        end
    end

    // Grant and valid decode straight from the state register so an
    // asynchronous reset drops them without waiting for a clock edge.
    assign bus.sl_arb_grant  = (state != IDLE) ?
                               (NUM_REQ'(1) << sel) : '0;
    assign bus.sl_addr       = (state == XFER) ? ptr : hd_sel;
    assign bus.out_data      = bus.sl_data;
    assign bus.out_valid     = (state == XFER);
    assign bus.out_src       = sel;
    assign bus.sl_latch_tail = (state == RELEASE);
    assign bus.abort         = abort_q;
    assign bus.frames_served = served;

endmodule

// File: tb/tb_slave_bus_arbiter.sv
// tb_slave_bus_arbiter: directed scoreboard bench for slave_bus_arbiter.
// Models four FIFO requesters with address-derived contents.
module tb_slave_bus_arbiter;

    typedef struct packed {
        logic [1:0] src;
        logic [8:0] addr;
        logic [8:0] data;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       out_ready;
    logic [1:0] gidx;

    logic [8:0] hb [4];
    logic [8:0] tl [4];
    int         more [4];
    int         mlen [4];

    exp_t       sb [$];
    int         glog [$];
    bit         rdy_pat [$];

    int vectors;
    int miscompares;
    int n_latch;
    int n_abort;
    int n_accept;
    int n_valid;
    int stall_n;
    int fs_exp;
    int abort_cnt;
    int abort_src;
    logic [3:0] drop_pend;
    logic [3:0] prev_grant;
    logic       prev_stall;
    logic [8:0] prev_data;

    slave_bus_arbiter_if #(.NUM_REQ(4), .IDX_W(2)) bus ();

    slave_bus_arbiter #(.NUM_REQ(4), .IDX_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [8:0] data_of(input int r, input int a);
        return 9'((r * 131 + a * 7 + 5) % 512);
    endfunction

    assign bus.sl_arb_request = req;
    assign bus.out_ready      = out_ready;

    always_comb begin
        gidx = 2'd0;
        for (int i = 0; i < 4; i++)
            if (bus.sl_arb_grant[i])
                gidx = 2'(i);
    end

    assign bus.sl_data = (bus.sl_arb_grant != 4'd0) ?
                         data_of(int'(gidx), int'(bus.sl_addr)) : 9'd0;
    assign bus.sl_tail = tl[gidx];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input int r, input int len);
        exp_t e;
        int a;
        tl[r] = 9'((int'(hb[r]) + len) % 512);
        for (int i = 0; i < len; i++) begin
            a      = (int'(hb[r]) + i) % 512;
            e.src  = 2'(r);
            e.addr = 9'(a);
            e.data = data_of(r, a);
            sb.push_back(e);
        end
        req[r] = 1'b1;
    endtask

    task automatic cyc();
        exp_t e;
        int r;
        @(posedge clk);
        #1;
        if (drop_pend != 4'd0) begin
            req       = req & ~drop_pend;
            drop_pend = 4'd0;
        end
        if (bus.out_valid && rdy_pat.size() > 0)
            out_ready = rdy_pat.pop_front();
        #1;
        if (bus.sl_arb_grant != 4'd0) begin
            chk("onehot", 32'($onehot(bus.sl_arb_grant)), 32'd1);
            if (prev_grant == 4'd0)
                glog.push_back(int'(gidx));
        end
        if (bus.out_valid)
            n_valid++;
        if (prev_stall && bus.out_valid) begin
            stall_n++;
            chk("stable", 32'(bus.out_data), 32'(prev_data));
        end
        prev_stall = bus.out_valid && !out_ready;
        prev_data  = bus.out_data;
        if (bus.out_valid && out_ready && |(req & bus.sl_arb_grant)) begin
            n_accept++;
            if (sb.size() == 0) begin
                chk("sb_empty", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("data", 32'(bus.out_data), 32'(e.data));
                chk("src", 32'(bus.out_src), 32'(e.src));
                chk("addr", 32'(bus.sl_addr), 32'(e.addr));
                if (abort_cnt > 0 && int'(e.src) == abort_src) begin
                    abort_cnt--;
                    if (abort_cnt == 0)
                        drop_pend = 4'(1 << abort_src);
                end
            end
        end
        if (bus.sl_latch_tail) begin
            n_latch++;
            if (fs_exp < 65535)
                fs_exp++;
            r     = int'(gidx);
            hb[r] = tl[r];
            if (more[r] > 0) begin
                more[r]--;
                push_frame(r, mlen[r]);
            end else begin
                req[r] = 1'b0;
            end
        end
        if (bus.abort)
            n_abort++;
        prev_grant = bus.sl_arb_grant;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc();
    endtask

    task automatic run_until(input string tag, input int want_latch,
                             input int want_abort, input int limit);
        int c;
        c = 0;
        while ((n_latch < want_latch || n_abort < want_abort) && c < limit) begin
            cyc();
            c++;
        end
        chk(tag, 32'(n_latch >= want_latch && n_abort >= want_abort), 32'd1);
    endtask

    task automatic model_reset();
        sb.delete();
        rdy_pat.delete();
        for (int i = 0; i < 4; i++) begin
            hb[i]   = 9'd0;
            tl[i]   = 9'd0;
            more[i] = 0;
            mlen[i] = 0;
        end
        req        = 4'd0;
        drop_pend  = 4'd0;
        abort_cnt  = 0;
        abort_src  = 0;
        fs_exp     = 0;
        prev_grant = 4'd0;
        prev_stall = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int l0;
        int a0;
        int s0;
        int v0;
        int g0;
        int rep;
        int c;
        vectors     = 0;
        miscompares = 0;
        n_latch     = 0;
        n_abort     = 0;
        n_accept    = 0;
        n_valid     = 0;
        stall_n     = 0;
        prev_data   = 9'd0;
        out_ready   = 1'b0;
        rst         = 1'b1;
        model_reset();

        // reset state
        #12;
        chk("rst_grant", 32'(bus.sl_arb_grant), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_latch", 32'(bus.sl_latch_tail), 32'd0);
        chk("rst_abort", 32'(bus.abort), 32'd0);
        chk("rst_frames", 32'(bus.frames_served), 32'd0);
        chk("rst_addr", 32'(bus.sl_addr), 32'd0);
        chk("rst_src", 32'(bus.out_src), 32'd0);
        #1;
        rst = 1'b0;

        // single frame of three words from requester 0
        out_ready = 1'b1;
        l0 = n_latch;
        a0 = n_accept;
        push_frame(0, 3);
        run_until("t1_done", l0 + 1, n_abort, 30);
        idle(2);
        chk("t1_latch", 32'(n_latch - l0), 32'd1);
        chk("t1_accepts", 32'(n_accept - a0), 32'd3);
        chk("t1_frames", 32'(bus.frames_served), 32'(fs_exp));
        chk("t1_hd0", 32'(bus.sl_addr), 32'd3);

        // round robin, all requesters with two one-word frames each
        do_reset();
        g0 = glog.size();
        l0 = n_latch;
        for (int r = 0; r < 4; r++) begin
            more[r] = 1;
            mlen[r] = 1;
            push_frame(r, 1);
        end
        run_until("t2_done", l0 + 8, n_abort, 80);
        idle(2);
        chk("t2_ngrants", 32'(glog.size() - g0), 32'd8);
        if (glog.size() - g0 >= 5) begin
            chk("t2_g0", 32'(glog[g0]), 32'd0);
            chk("t2_g1", 32'(glog[g0 + 1]), 32'd1);
            chk("t2_g2", 32'(glog[g0 + 2]), 32'd2);
            chk("t2_g3", 32'(glog[g0 + 3]), 32'd3);
            chk("t2_g4", 32'(glog[g0 + 4]), 32'd0);
        end
        rep = 0;
        for (int i = g0 + 1; i < glog.size(); i++)
            if (glog[i] == glog[i - 1])
                rep++;
        chk("t2_repeats", 32'(rep), 32'd0);
        chk("t2_frames", 32'(bus.frames_served), 32'(fs_exp));

        // backpressure on a two-word frame
        out_ready = 1'b0;
        rdy_pat.push_back(1'b1);
        rdy_pat.push_back(1'b0);
        rdy_pat.push_back(1'b0);
        rdy_pat.push_back(1'b1);
        l0 = n_latch;
        a0 = n_accept;
        s0 = stall_n;
        push_frame(1, 2);
        run_until("t3_done", l0 + 1, n_abort, 30);
        chk("t3_accepts", 32'(n_accept - a0), 32'd2);
        chk("t3_stalls", 32'(stall_n - s0), 32'd2);
        out_ready = 1'b1;
        idle(2);
        chk("t3_frames", 32'(bus.frames_served), 32'(fs_exp));

        // walk requester 1 head to 510, then a frame wrapping past 511
        l0 = n_latch;
        push_frame(1, 510 - int'(hb[1]));
        run_until("t4_fill", l0 + 1, n_abort, 600);
        idle(2);
        chk("t4_hd510", 32'(bus.sl_addr), 32'd510);
        l0 = n_latch;
        a0 = n_accept;
        push_frame(1, 4);
        run_until("t4_wrap", l0 + 1, n_abort, 30);
        idle(2);
        chk("t4_wrap_acc", 32'(n_accept - a0), 32'd4);
        chk("t4_hd2", 32'(bus.sl_addr), 32'd2);
        // empty frame: tail equals head
        l0 = n_latch;
        v0 = n_valid;
        push_frame(1, 0);
        run_until("t4_empty", l0 + 1, n_abort, 20);
        idle(2);
        chk("t4_novalid", 32'(n_valid - v0), 32'd0);
        chk("t4_frames", 32'(bus.frames_served), 32'(fs_exp));

        // abort after one of four words from requester 2
        l0 = n_latch;
        abort_src = 2;
        abort_cnt = 1;
        push_frame(2, 4);
        run_until("t5_abort", l0, n_abort + 1, 30);
        chk("t5_left", 32'(sb.size()), 32'd3);
        sb.delete();
        idle(2);
        chk("t5_nolatch", 32'(n_latch - l0), 32'd0);
        chk("t5_hd2", 32'(bus.sl_addr), 32'(hb[2]));
        chk("t5_frames", 32'(bus.frames_served), 32'(fs_exp));
        // rotating pointer now at 3
        g0 = glog.size();
        l0 = n_latch;
        push_frame(3, 1);
        push_frame(0, 1);
        push_frame(2, 1);
        run_until("t5_rr", l0 + 3, n_abort, 40);
        idle(2);
        if (glog.size() > g0)
            chk("t5_first", 32'(glog[g0]), 32'd3);
        else
            chk("t5_nogrant", 32'(glog.size() - g0), 32'd1);

        // asynchronous reset in the middle of a transfer
        a0 = n_accept;
        push_frame(0, 10);
        c = 0;
        while (n_accept < a0 + 3 && c < 40) begin
            cyc();
            c++;
        end
        chk("t6_started", 32'(n_accept >= a0 + 3), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_grant", 32'(bus.sl_arb_grant), 32'd0);
        chk("t6_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_latch", 32'(bus.sl_latch_tail), 32'd0);
        chk("t6_frames", 32'(bus.frames_served), 32'd0);
        chk("t6_addr", 32'(bus.sl_addr), 32'd0);
        chk("t6_src", 32'(bus.out_src), 32'd0);
        model_reset();
        #2;
        rst = 1'b0;
        l0 = n_latch;
        push_frame(3, 2);
        run_until("t6_resume", l0 + 1, n_abort, 30);
        idle(2);
        chk("t6_frames1", 32'(bus.frames_served), 32'd1);
        chk("t6_hd3", 32'(bus.sl_addr), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/slave_bus_arbiter.md
SLAVE_BUS_ARBITER -- requirements
Module: slave_bus_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of bus_interface requesters sharing the slave bus (2..8).
REQ-002 Parameter: IDX_W, default 2, width of the source index; SHALL equal ceil(log2(NUM_REQ)).
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 sl_arb_request  input  NUM_REQ  per-requester frame-pending flag.
REQ-006 sl_arb_grant  output  NUM_REQ  one-hot grant; the granted requester drives sl_data/sl_tail.
REQ-007 sl_addr  output  9  read address presented to the granted requester's FIFO.
REQ-008 sl_data  input  9  read data from the granted requester, combinational from sl_addr.
REQ-009 sl_tail  input  9  granted requester's frame end address (one past the last word).
REQ-010 sl_latch_tail  output  1  one-cycle pulse releasing the served frame.
REQ-011 out_data  output  9  word forwarded downstream; equals sl_data.
REQ-012 out_valid  output  1  out_data valid.
REQ-013 out_ready  input  1  downstream accept.
REQ-014 out_src  output  IDX_W  index of the granted requester.
REQ-015 abort  output  1  one-cycle pulse when a transfer is abandoned.
REQ-016 frames_served  output  16  count of completed frames.

Function
REQ-017 The FSM SHALL have states IDLE, GRANT, XFER and RELEASE.
REQ-018 Per-requester head pointer hd[i] (9 bits), rotating priority pointer rr (IDX_W bits), selected index sel, latched tail tail_q and read pointer ptr SHALL be held.
REQ-019 IDLE: if any request is set, sel SHALL be the first set request at or after rr, scanning upward with wrap; next state GRANT; no grant is asserted in IDLE.
REQ-020 sl_arb_grant SHALL be one-hot at bit sel in GRANT, XFER and RELEASE, and all-zero otherwise.
REQ-021 GRANT (one cycle): tail_q <= sl_tail and ptr <= hd[sel]; if sl_tail == hd[sel], the next state SHALL be RELEASE (empty frame), else XFER.
REQ-022 XFER: sl_addr = ptr; out_valid = 1; out_data = sl_data; out_src = sel.
REQ-023 XFER handshake: a word transfers only on a cycle with out_valid & out_ready; ptr then increments modulo 512.
REQ-024 out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-025 XFER exit: a transfer with ptr+1 == tail_q (mod 512) SHALL move to RELEASE.
REQ-026 RELEASE (one cycle): sl_latch_tail=1; hd[sel] <= tail_q; rr <= (sel+1) mod NUM_REQ; frames_served increments, saturating at 0xFFFF; next state IDLE.
REQ-027 Abort: if sl_arb_request[sel] falls in GRANT or XFER, the FSM SHALL go to IDLE next cycle with abort=1.
REQ-028 On abort, there SHALL be no sl_latch_tail and hd[sel] SHALL be unchanged; rr <= (sel+1) mod NUM_REQ.
REQ-029 Abort takes precedence over an accept in the same cycle: the word is not counted and ptr is not advanced.
REQ-030 Head/tail arithmetic SHALL be 9-bit modulo 512; a frame crossing address 511->0 SHALL transfer correctly.
REQ-031 Outside XFER, out_valid=0 and sl_addr=hd[sel].
REQ-032 Requests arriving during an active grant SHALL wait; arbitration happens only in IDLE.
REQ-033 Minimum overhead per frame SHALL be 3 cycles (IDLE, GRANT, RELEASE) plus one cycle per accepted word.

Reset
REQ-034 On rst, asynchronously: state=IDLE, grant=0, sl_latch_tail=0, out_valid=0, abort=0, all hd[i]=0, rr=0, sel=0, ptr=0, tail_q=0, frames_served=0, sl_addr=0, out_src=0.
REQ-035 Reset asserted mid-transfer SHALL drop the grant immediately, with no sl_latch_tail pulse.
REQ-036 After reset release, arbitration SHALL resume in IDLE on the first clock edge.

Verification
REQ-037 Single frame: req[0]=1, tail=3, out_ready=1 -> words at addr 0,1,2 on out_data; sl_latch_tail pulses once; hd[0]=3; frames_served=1.
REQ-038 Round-robin: req=4'b1111 held, every frame 1 word -> grant order 0,1,2,3,0; no requester granted twice in a row.
REQ-039 Backpressure: out_ready toggles 1,0,0,1 during a 2-word frame -> out_data stable while stalled; exactly 2 accepts; latch_tail after the 2nd.
REQ-040 Wrap and empty: hd[1]=510, tail=2 -> addresses 510,511,0,1 transferred; a later frame with tail==hd -> RELEASE with no out_valid, frames_served +1.
REQ-041 Abort: req[2] dropped after 1 of 4 words -> abort pulse; no latch_tail; hd[2] unchanged; rr=3.
REQ-042 Async reset mid-XFER: rst pulsed -> grant=0 and out_valid=0 immediately, with no clock edge; all counters 0.
